// File: rtl/bitcnt_pkg.sv
// Shared definitions for the bitcnt counter and its pattern generator.
// Func codes: bit 2 selects popcount, bit 1 selects trailing (vs leading) zeros,
// bit 0 selects the 32-bit operand width. Codes 11x are illegal.
package bitcnt_pkg;

    localparam logic [2:0] FUNC_CLZ64  = 3'b000;
    localparam logic [2:0] FUNC_CLZ32  = 3'b001;
    localparam logic [2:0] FUNC_CTZ64  = 3'b010;
    localparam logic [2:0] FUNC_CTZ32  = 3'b011;
    localparam logic [2:0] FUNC_PCNT64 = 3'b100;
    localparam logic [2:0] FUNC_PCNT32 = 3'b101;

    localparam int FUNC_MODE32 = 0;
    localparam int FUNC_NOREV  = 1;
    localparam int FUNC_POP    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_DONE  = 2'd2
    } gen_state_t;

    // Operand width in bits for a func code (32 or 64).
    function automatic logic [6:0] func_width(input logic [2:0] func);
        return func[FUNC_MODE32] ? 7'd32 : 7'd64;
    endfunction

    // Popcount with the "no reverse" bit set has no meaning.
    function automatic logic func_illegal(input logic [2:0] func);
        return func[FUNC_POP] && func[FUNC_NOREV];
    endfunction

endpackage

// File: rtl/bitcnt_pattern_gen_if.sv
// Request/result handshake bundle for bitcnt_pattern_gen.
// master = request source / result sink, slave = the generator.
// Both directions are plain valid/ready.
interface bitcnt_pattern_gen_if;

    logic        din_valid;
    logic        din_ready;
    logic [6:0]  din_count;
    logic [2:0]  din_func;
    logic        dout_valid;
    logic        dout_ready;
    logic [63:0] dout_data;
    logic        dout_err;

    modport master (
        output din_valid, din_count, din_func, dout_ready,
        input  din_ready, dout_valid, dout_data, dout_err
    );

    modport slave (
        input  din_valid, din_count, din_func, dout_ready,
        output din_ready, dout_valid, dout_data, dout_err
    );

endinterface

// File: rtl/bitcnt_pattern_chunk.sv
// Computes STEP bits of the canonical operand starting at bit index base.
// Latency: purely combinational.
// Backpressure: none; the parent decides when the chunk is written.
module bitcnt_pattern_chunk
    import bitcnt_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic [6:0]      base,
    input  logic [6:0]      count,
    input  logic [2:0]      func,
    output logic [STEP-1:0] bits
);

    int w;
    int n;

    // Bits at or above the operand width stay zero; CLZ only matches when n < W
    // so W-1-n never wraps.
    always_comb begin
        w    = int'(func_width(func));
        n    = int'(count);
        bits = '0;
        for (int j = 0; j < STEP; j++) begin
            if (int'(base) + j < w) begin
                if (func[FUNC_POP]) begin
                    bits[j] = (int'(base) + j < n);
                end else if (func[FUNC_NOREV]) begin
                    bits[j] = (int'(base) + j == n);
                end else begin
                    bits[j] = (n <= w - 1) && (int'(base) + j == w - 1 - n);
                end
            end
        end
    end

endmodule

// File: rtl/bitcnt_pattern_gen.sv
// Builds the 64-bit operand that makes bitcnt return a given count, STEP bits per cycle.
// Latency: accept at edge t -> dout_valid after edge t+64/STEP; one result per N+1 cycles.
// Backpressure: result held stable while dout_ready is low; din_ready low until it drains.
module bitcnt_pattern_gen
    import bitcnt_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic                clock,
    input  logic                reset,
    bitcnt_pattern_gen_if.slave io
);

    localparam int            N      = 64 / STEP;
    localparam int            KW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    gen_state_t      state;
    logic [KW-1:0]   k;
    logic [6:0]      cnt_q;
    logic [2:0]      func_q;
    logic            err_q;
    logic [63:0]     data_q;
    logic [5:0]      base;
    logic [STEP-1:0] chunk_bits;
    logic            accept;

    assign base = 6'(int'(k) * STEP);

    // A finished result can be swapped for a new request in the same cycle.
    assign io.din_ready  = (state == ST_IDLE) || ((state == ST_DONE) && io.dout_ready);
    assign accept        = io.din_valid && io.din_ready;
    assign io.dout_valid = (state == ST_DONE);
    assign io.dout_data  = data_q;
    assign io.dout_err   = err_q;

    bitcnt_pattern_chunk #(
        .STEP (STEP)
    ) u_chunk (
        .base  ({1'b0, base}),
        .count (cnt_q),
        .func  (func_q),
        .bits  (chunk_bits)
    );

    // Request/build/result FSM; illegal requests run the full build with the chunk masked to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            k      <= '0;
            cnt_q  <= '0;
            func_q <= '0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        cnt_q  <= io.din_count;
                        func_q <= io.din_func;
                        err_q  <= func_illegal(io.din_func) ||
                                  (io.din_count > func_width(io.din_func));
                        data_q <= '0;
                        k      <= '0;
                        state  <= ST_BUILD;
                    end else if ((state == ST_DONE) && io.dout_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUILD: begin
                    data_q[base +: STEP] <= chunk_bits & {STEP{~err_q}};
                    if (k == K_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitcnt_pattern_gen.sv
// Bench for bitcnt_pattern_gen at STEP 1, 8 and 64 sharing one clock and reset.
// Directed vectors and corner sequences run on the STEP=8 instance, then all three
// instances run randomized traffic against a behavioural model.
module tb_bitcnt_pattern_gen;
    import bitcnt_pkg::*;

    logic clock;
    logic reset;

    logic        req_vld  [3];
    logic [6:0]  req_cnt  [3];
    logic [2:0]  req_func [3];
    logic        rsp_rdy  [3];
    logic        acc_rdy  [3];
    logic        rsp_vld  [3];
    logic [63:0] rsp_dat  [3];
    logic        rsp_err  [3];

    int n_pass  = 0;
    int n_total = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : (g == 1) ? 8 : 64;
        bitcnt_pattern_gen_if ifc ();
        assign ifc.din_valid  = req_vld[g];
        assign ifc.din_count  = req_cnt[g];
        assign ifc.din_func   = req_func[g];
        assign ifc.dout_ready = rsp_rdy[g];
        assign acc_rdy[g]     = ifc.din_ready;
        assign rsp_vld[g]     = ifc.dout_valid;
        assign rsp_dat[g]     = ifc.dout_data;
        assign rsp_err[g]     = ifc.dout_err;
        bitcnt_pattern_gen #(.STEP(S)) u_dut (
            .clock (clock),
            .reset (reset),
            .io    (ifc)
        );
    end

    function automatic int step_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 8 : 64;
    endfunction

    // Expected operand straight from the counting rules.
    function automatic logic [63:0] ref_pattern(input logic [2:0] f, input int n, output logic err);
        int w;
        w   = f[0] ? 32 : 64;
        err = (f[2] && f[1]) || (n > w);
        if (err) return 64'd0;
        if (f[2]) return (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        if (f[1]) return (n < w) ? (64'd1 << n) : 64'd0;
        return (n < w) ? (64'd1 << (w - 1 - n)) : 64'd0;
    endfunction

    // What bitcnt would report for an operand.
    function automatic int bitcnt_ref(input logic [63:0] v, input logic [2:0] f);
        int w;
        int c;
        w = f[0] ? 32 : 64;
        c = 0;
        if (f[2]) begin
            for (int i = 0; i < w; i++) c += int'(v[i]);
        end else if (f[1]) begin
            while (c < w && !v[c]) c++;
        end else begin
            while (c < w && !v[w - 1 - c]) c++;
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One request with dout_ready held high; lat = edges from accept to dout_valid.
    task automatic do_req(input int d, input logic [2:0] f, input logic [6:0] c,
                          output logic [63:0] data, output logic err, output int lat);
        int k;
        data = '0;
        err  = 1'b0;
        lat  = -1;
        @(negedge clock);
        req_func[d] = f;
        req_cnt[d]  = c;
        req_vld[d]  = 1'b1;
        rsp_rdy[d]  = 1'b1;
        #1;
        k = 0;
        while (!acc_rdy[d] && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        @(negedge clock);
        req_vld[d]  = 1'b0;
        req_cnt[d]  = 7'($urandom_range(0, 127));
        req_func[d] = 3'($urandom_range(0, 7));
        #1;
        k = 1;
        while (!rsp_vld[d] && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        if (rsp_vld[d]) begin
            data = rsp_dat[d];
            err  = rsp_err[d];
            lat  = k - 1;
        end
    endtask

    // Randomized requests with random gaps and backpressure on instance d.
    task automatic run_random(input int d, input int n_req);
        int          n;
        int          sent;
        int          got;
        int          cyc;
        int          acc_cyc;
        int          budget;
        bit          pending;
        bit          in_flight;
        bit          seen;
        logic [63:0] e_data;
        logic        e_err;
        logic [6:0]  e_cnt;
        logic [2:0]  e_func;
        n         = 64 / step_of(d);
        sent      = 0;
        got       = 0;
        cyc       = 0;
        acc_cyc   = 0;
        pending   = 0;
        in_flight = 0;
        seen      = 0;
        e_data    = '0;
        e_err     = 1'b0;
        e_cnt     = '0;
        e_func    = '0;
        budget    = n_req * (n + 1) * 6 + 200;
        while (got < n_req && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (!pending) begin
                req_func[d] = 3'($urandom_range(0, 7));
                req_cnt[d]  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127))
                                                          : 7'($urandom_range(0, 65));
                req_vld[d]  = 1'b0;
                if (sent < n_req && $urandom_range(0, 3) != 0) begin
                    req_vld[d] = 1'b1;
                    pending    = 1;
                    sent++;
                end
            end
            rsp_rdy[d] = ($urandom_range(0, 3) != 0);
            #1;
            if (rsp_vld[d]) begin
                if (!seen) begin
                    seen = 1;
                    check($sformatf("rand_s%0d_inflight", step_of(d)), 64'(in_flight), 64'd1);
                    check($sformatf("rand_s%0d_latency", step_of(d)), 64'(cyc - acc_cyc - 1), 64'(n));
                end
                if (rsp_rdy[d]) begin
                    check($sformatf("rand_s%0d_data f%0d n%0d", step_of(d), e_func, e_cnt),
                          rsp_dat[d], e_data);
                    check($sformatf("rand_s%0d_err f%0d n%0d", step_of(d), e_func, e_cnt),
                          64'(rsp_err[d]), 64'(e_err));
                    if (!e_err)
                        check($sformatf("rand_s%0d_bitcnt f%0d", step_of(d), e_func),
                              64'(bitcnt_ref(rsp_dat[d], e_func)), 64'(e_cnt));
                    got++;
                    seen      = 0;
                    in_flight = 0;
                end
            end
            if (req_vld[d] && acc_rdy[d]) begin
                e_func    = req_func[d];
                e_cnt     = req_cnt[d];
                e_data    = ref_pattern(e_func, int'(e_cnt), e_err);
                acc_cyc   = cyc;
                pending   = 0;
                in_flight = 1;
            end
        end
        check($sformatf("rand_s%0d_completed", step_of(d)), 64'(got), 64'(n_req));
        @(negedge clock);
        req_vld[d] = 1'b0;
        rsp_rdy[d] = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  func;
        logic [6:0]  cnt;
        logic [63:0] data;
        logic        err;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [63:0] data;
        logic        err;
        int          lat;
        int          k;

        vecs[0]  = '{FUNC_CLZ64,  7'd0,  64'h8000_0000_0000_0000, 1'b0};
        vecs[1]  = '{FUNC_CLZ64,  7'd63, 64'h0000_0000_0000_0001, 1'b0};
        vecs[2]  = '{FUNC_CLZ64,  7'd64, 64'h0000_0000_0000_0000, 1'b0};
        vecs[3]  = '{FUNC_CLZ32,  7'd31, 64'h0000_0000_0000_0001, 1'b0};
        vecs[4]  = '{FUNC_CTZ32,  7'd5,  64'h0000_0000_0000_0020, 1'b0};
        vecs[5]  = '{FUNC_CTZ32,  7'd32, 64'h0000_0000_0000_0000, 1'b0};
        vecs[6]  = '{FUNC_CLZ32,  7'd33, 64'h0000_0000_0000_0000, 1'b1};
        vecs[7]  = '{FUNC_PCNT64, 7'd64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[8]  = '{FUNC_PCNT32, 7'd32, 64'h0000_0000_FFFF_FFFF, 1'b0};
        vecs[9]  = '{FUNC_PCNT32, 7'd40, 64'h0000_0000_0000_0000, 1'b1};
        vecs[10] = '{3'b110,      7'd5,  64'h0000_0000_0000_0000, 1'b1};
        vecs[11] = '{3'b111,      7'd0,  64'h0000_0000_0000_0000, 1'b1};
        vecs[12] = '{FUNC_CTZ64,  7'd63, 64'h8000_0000_0000_0000, 1'b0};
        vecs[13] = '{FUNC_CLZ32,  7'd0,  64'h0000_0000_8000_0000, 1'b0};
        vecs[14] = '{FUNC_PCNT64, 7'd0,  64'h0000_0000_0000_0000, 1'b0};
        vecs[15] = '{FUNC_CTZ64,  7'd65, 64'h0000_0000_0000_0000, 1'b1};

        for (int d = 0; d < 3; d++) begin
            req_vld[d]  = 1'b0;
            req_cnt[d]  = '0;
            req_func[d] = '0;
            rsp_rdy[d]  = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_din_ready_s%0d", step_of(d)), 64'(acc_rdy[d]), 64'd1);
            check($sformatf("reset_dout_valid_s%0d", step_of(d)), 64'(rsp_vld[d]), 64'd0);
            check($sformatf("reset_dout_data_s%0d", step_of(d)), rsp_dat[d], 64'd0);
            check($sformatf("reset_dout_err_s%0d", step_of(d)), 64'(rsp_err[d]), 64'd0);
        end

        // Directed vectors on STEP=8 (latency 8 edges).
        for (int i = 0; i < 16; i++) begin
            do_req(1, vecs[i].func, vecs[i].cnt, data, err, lat);
            check($sformatf("vec%0d_data", i), data, vecs[i].data);
            check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].err));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
        end

        // Backpressure hold, then back-to-back accept in the draining cycle.
        @(negedge clock);
        req_func[1] = FUNC_PCNT64;
        req_cnt[1]  = 7'd10;
        req_vld[1]  = 1'b1;
        rsp_rdy[1]  = 1'b0;
        #1;
        check("bp_first_accept", 64'(acc_rdy[1]), 64'd1);
        @(negedge clock);
        req_vld[1] = 1'b0;
        #1;
        k = 1;
        while (!rsp_vld[1] && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("bp_latency", 64'(k - 1), 64'd8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            req_func[1] = FUNC_CTZ64;
            req_cnt[1]  = 7'd7;
            req_vld[1]  = 1'b1;
            #1;
            check($sformatf("bp_hold_valid_%0d", i), 64'(rsp_vld[1]), 64'd1);
            check($sformatf("bp_hold_data_%0d", i), rsp_dat[1], 64'h3FF);
            check($sformatf("bp_hold_din_ready_%0d", i), 64'(acc_rdy[1]), 64'd0);
        end
        @(negedge clock);
        rsp_rdy[1] = 1'b1;
        #1;
        check("b2b_din_ready", 64'(acc_rdy[1]), 64'd1);
        check("b2b_old_data", rsp_dat[1], 64'h3FF);
        @(negedge clock);
        req_vld[1] = 1'b0;
        #1;
        check("b2b_valid_drop", 64'(rsp_vld[1]), 64'd0);
        k = 1;
        while (!rsp_vld[1] && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("b2b_latency", 64'(k - 1), 64'd8);
        check("b2b_data", rsp_dat[1], 64'h80);
        check("b2b_err", 64'(rsp_err[1]), 64'd0);

        // Reset in the third BUILD cycle discards the partial operand.
        @(negedge clock);
        req_func[1] = FUNC_PCNT64;
        req_cnt[1]  = 7'd64;
        req_vld[1]  = 1'b1;
        #1;
        check("rst_build_accept", 64'(acc_rdy[1]), 64'd1);
        @(negedge clock);
        req_vld[1] = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_build_partial", rsp_dat[1], 64'h0000_0000_0000_FFFF);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_build_valid", 64'(rsp_vld[1]), 64'd0);
        check("rst_build_data", rsp_dat[1], 64'd0);
        check("rst_build_din_ready", 64'(acc_rdy[1]), 64'd1);
        do_req(1, FUNC_CTZ32, 7'd17, data, err, lat);
        check("rst_build_next_data", data, 64'h0002_0000);
        check("rst_build_next_latency", 64'(lat), 64'd8);

        // Reset while a result is waiting: handshake in that cycle does not complete.
        @(negedge clock);
        req_func[1] = FUNC_CLZ32;
        req_cnt[1]  = 7'd0;
        req_vld[1]  = 1'b1;
        rsp_rdy[1]  = 1'b0;
        @(negedge clock);
        req_vld[1] = 1'b0;
        #1;
        k = 1;
        while (!rsp_vld[1] && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("rst_done_data_before", rsp_dat[1], 64'h8000_0000);
        reset      = 1'b1;
        rsp_rdy[1] = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_done_valid", 64'(rsp_vld[1]), 64'd0);
        check("rst_done_data", rsp_dat[1], 64'd0);
        check("rst_done_err", 64'(rsp_err[1]), 64'd0);
        do_req(1, FUNC_PCNT32, 7'd3, data, err, lat);
        check("rst_done_next_data", data, 64'h7);

        fork
            run_random(0, 400);
            run_random(1, 2500);
            run_random(2, 5000);
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
